i2s_receiver: RTL
=================

# i2s_receiver

Serial-to-parallel I2S capture stage for the audio ADC path. It samples the ADC serial data line using the bit and word clocks from `i2s_clock_divider`, and deserialises 24-bit left/right samples MSB-first in standard I2S format. It presents each completed stereo pair to the effect core with a one-cycle `valid` strobe. Its output format matches the `ldata`/`rdata` inputs of `i2s_transmitter`, so the two blocks can be connected back to back for loopback.

## Interface
- `DATA_WIDTH`, 24: sample bits captured per channel, MSB first.
- `SLOT_WIDTH`, 32: sclk periods per channel slot. Must be ≥ `DATA_WIDTH`+1.

- `mclk`  in  1: master clock; the only clock in the block; all flops on rising edge.
- `rst`  in  1: reset, asynchronous, active-low; clears all state while low.
- `sclk`  in  1: I2S bit clock, sampled as data in the `mclk` domain.
- `lrclk`  in  1: I2S word select, sampled as data; 0 = left, 1 = right.
- `sdin`  in  1: I2S serial data from the ADC.
- `ldata`  out  DATA_WIDTH: last completed left sample.
- `rdata`  out  DATA_WIDTH: last completed right sample.
- `valid`  out  1: one-`mclk` pulse when `ldata`/`rdata` update together.
- `frame_err`  out  1: sticky; set when any slot length ≠ `SLOT_WIDTH`.

## Operation
- **Input stage.** `sclk`, `lrclk` and `sdin` are registered into stage s1. A delayed copy s2 of `sclk` is also kept.
- **Bit event.** A bit event is s1.`sclk` = 1 and s2.`sclk` = 0. All capture logic advances only on bit events.
- **Slot boundary.** A slot boundary is a bit event where s1.`lrclk` differs from `lrclk` latched at the previous bit event.
  - The `sdin` bit sampled on the boundary event belongs to the previous slot and is discarded.
  - This gives the standard I2S one-bit delay.
- **Bit counter.** The counter is cleared to 0 on a boundary and incremented on every other bit event.
  - Counts 1..`DATA_WIDTH` shift `sdin` into the active shift register, MSB first.
  - Bits beyond `DATA_WIDTH` are ignored.
  - The counter saturates at `SLOT_WIDTH`.
- **State machine.**
  - WAIT: entered from reset. Ignores data until a boundary with new `lrclk` = 0, then goes to LEFT. No `valid` and no `frame_err` check on that first boundary.
  - LEFT: on a boundary with new `lrclk` = 1, copy the left shift register into the left hold register, then go to RIGHT.
  - RIGHT: on a boundary with new `lrclk` = 0, do all of the following, then go to LEFT:
    - load `ldata` ← left hold register;
    - load `rdata` ← right shift register (including the final bit shifted on this cycle, if any);
    - pulse `valid`.
- **Framing check.** At each boundary in LEFT/RIGHT, if slot bit events (boundary event + counted events) ≠ `SLOT_WIDTH`, `frame_err` is set to 1. It stays 1 until reset.
- **Reset.** While `rst` = 0:
  - `ldata` = 0, `rdata` = 0, `valid` = 0, `frame_err` = 0;
  - shift and hold registers = 0, counter = 0, state = WAIT.
- **Reset mid-frame.** Asserting `rst` mid-frame discards the partial frame. After release, the first `valid` follows one complete left+right frame that starts on a left boundary.

## Timing
- Requirements on the clock ratios:
  - `sclk` period ≥ 4 `mclk` periods;
  - `sclk` high and low phases each ≥ 2 `mclk` periods;
  - `lrclk` and `sdin` change only on `sclk` falling edges.
- Latency from the `sclk` rising edge (at the pins) that closes a frame to `valid` high: 2 `mclk` cycles, or 3 with the synchroniser option.
- `valid` is high for exactly 1 `mclk` cycle per stereo frame. `ldata`/`rdata` change only in that cycle and hold until the next frame.
- A boundary and a counted bit event cannot occur on the same cycle; the boundary takes precedence by definition.

## Configuration
- Macro: `I2S_RX_SYNC_EN`.
- Defined: an extra register stage precedes s1 on `sclk`, `lrclk` and `sdin`, forming a 2-flop synchroniser for an external, asynchronous ADC. All latencies increase by 1 `mclk` cycle.
- Undefined: single register stage only. This is valid when `sclk`/`lrclk` come from `i2s_clock_divider` on the same `mclk`.

## Test plan
- Left 24'hABCDEF, right 24'h123456, 32-bit slots, 8 padding bits = 0 → after the right slot closes: one `valid` pulse, `ldata` = 24'hABCDEF, `rdata` = 24'h123456, `frame_err` = 0.
- Alternating frames of all-zeros / 24'hFFFFFF for both channels → exact values each frame. Exactly one `valid` per frame, spaced 64 sclk periods.
- Right slot shortened to 31 sclk periods → `frame_err` = 1 at the next boundary and remains 1 over 3 further good frames. Data keeps updating.
- `rst` pulsed low mid-right-slot → all outputs 0 immediately. No `valid` until one full left+right frame after release.
- Loopback `i2s_clock_divider` → `i2s_transmitter` → `i2s_receiver` with samples 50321, 2131, 34245, 12312, 9044432, 0, 16777215 → each received pair equals the transmitted pair, one frame later.
- Repeat the first scenario with `I2S_RX_SYNC_EN` defined → same values, `valid` one `mclk` later than in the undefined build.

Source files
------------

// File: rtl/i2s_receiver.sv
// I2S capture stage: deserialises 24-bit left/right samples from sclk/lrclk/sdin
// sampled in the mclk domain. Define I2S_RX_SYNC_EN to add a 2-flop input synchroniser.
module i2s_receiver #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  lrclk,
  input  logic                  sdin,
  output logic [DATA_WIDTH-1:0] ldata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  valid,
  output logic                  frame_err
);

  localparam int            CW       = $clog2(SLOT_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SLOT_WIDTH);
  localparam logic [CW-1:0] DATA_CNT = CW'(DATA_WIDTH);
  localparam logic [CW:0]   SLOT_LEN = (CW+1)'(SLOT_WIDTH);

  typedef enum logic [1:0] {S_WAIT, S_LEFT, S_RIGHT} state_t;

  typedef struct packed {
    logic sclk;
    logic lrclk;
    logic sdin;
  } pins_t;

  pins_t in_w;

`ifdef I2S_RX_SYNC_EN
  pins_t s0_q, s0_d;
  always_comb s0_d = '{sclk: sclk, lrclk: lrclk, sdin: sdin};
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) s0_q <= '0;
    else      s0_q <= s0_d;
  end
  assign in_w = s0_q;
`else
  assign in_w = '{sclk: sclk, lrclk: lrclk, sdin: sdin};
`endif

  pins_t                 s1_q, s1_d;
  logic                  s2_sclk_q, s2_sclk_d;
  logic                  lr_prev_q, lr_prev_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] lsr_q, lsr_d;
  logic [DATA_WIDTH-1:0] rsr_q, rsr_d;
  logic [DATA_WIDTH-1:0] lhold_q, lhold_d;
  logic [DATA_WIDTH-1:0] ldata_q, ldata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  state_t                state_q, state_d;

  logic bit_evt, bnd, slot_bad;

  always_comb begin
    s1_d      = in_w;
    s2_sclk_d = s1_q.sclk;
    lr_prev_d = lr_prev_q;
    cnt_d     = cnt_q;
    lsr_d     = lsr_q;
    rsr_d     = rsr_q;
    lhold_d   = lhold_q;
    ldata_d   = ldata_q;
    rdata_d   = rdata_q;
    valid_d   = 1'b0;
    ferr_d    = ferr_q;
    state_d   = state_q;

    bit_evt  = s1_q.sclk & ~s2_sclk_q;
    bnd      = bit_evt & (s1_q.lrclk != lr_prev_q);
    // The boundary event itself counts as one bit of the closing slot.
    slot_bad = (({1'b0, cnt_q} + 1'b1) != SLOT_LEN);

    if (bit_evt) begin
      lr_prev_d = s1_q.lrclk;
      if (bnd) begin
        cnt_d = '0;
        unique case (state_q)
          S_WAIT: begin
            if (!s1_q.lrclk) begin
              lsr_d   = '0;
              state_d = S_LEFT;
            end
          end
          S_LEFT: begin
            if (s1_q.lrclk) begin
              lhold_d = lsr_q;
              rsr_d   = '0;
              state_d = S_RIGHT;
              if (slot_bad) ferr_d = 1'b1;
            end
          end
          S_RIGHT: begin
            if (!s1_q.lrclk) begin
              ldata_d = lhold_q;
              rdata_d = rsr_q;
              valid_d = 1'b1;
              lsr_d   = '0;
              state_d = S_LEFT;
              if (slot_bad) ferr_d = 1'b1;
            end
          end
          default: state_d = S_WAIT;
        endcase
      end else begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // Counts 1..DATA_WIDTH carry sample bits; padding beyond is dropped.
        if (state_q != S_WAIT && cnt_q < DATA_CNT) begin
          if (lr_prev_q) rsr_d = {rsr_q[DATA_WIDTH-2:0], s1_q.sdin};
          else           lsr_d = {lsr_q[DATA_WIDTH-2:0], s1_q.sdin};
        end
      end
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      s1_q      <= '0;
      s2_sclk_q <= 1'b0;
      lr_prev_q <= 1'b0;
      cnt_q     <= '0;
      lsr_q     <= '0;
      rsr_q     <= '0;
      lhold_q   <= '0;
      ldata_q   <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      state_q   <= S_WAIT;
    end else begin
      s1_q      <= s1_d;
      s2_sclk_q <= s2_sclk_d;
      lr_prev_q <= lr_prev_d;
      cnt_q     <= cnt_d;
      lsr_q     <= lsr_d;
      rsr_q     <= rsr_d;
      lhold_q   <= lhold_d;
      ldata_q   <= ldata_d;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      state_q   <= state_d;
    end
  end

  assign ldata     = ldata_q;
  assign rdata     = rdata_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;

endmodule
